// File: rtl/prbs10_checker.sv
// prbs10_checker: self-synchronising receiver for the 10-bit PRBS link.
// Optional macro PRBS_CHK_CLR_EN adds err_clr, a synchronous err_cnt clear.
`timescale 1ns/1ps
module prbs10_checker #(
  parameter int LOCK_MATCH = 16,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
`ifdef PRBS_CHK_CLR_EN
  input  logic             err_clr,
`endif
  output logic             lock,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [9:0]       state_word
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [9:0]       r_hist;
  logic [9:0]       w_hist_nx;
  logic [3:0]       r_fill;
  logic [3:0]       w_fill_nx;
  logic [7:0]       r_match;
  logic [7:0]       w_match_nx;
  logic [7:0]       r_miss;
  logic [7:0]       w_miss_nx;
  logic             r_lock;
  logic             r_err_pulse;
  logic             w_err_nx;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] w_cnt_nx;
  logic             w_pred;
  logic             w_clr;

  assign w_pred = r_hist[9] ^ r_hist[5] ^ r_hist[0];

`ifdef PRBS_CHK_CLR_EN
  assign w_clr = err_clr;
`else
  assign w_clr = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_hist_nx  = r_hist;
    w_fill_nx  = r_fill;
    w_match_nx = r_match;
    w_miss_nx  = r_miss;
    w_err_nx   = 1'b0;
    w_cnt_nx   = r_err_cnt;
    if (din_valid) begin
      unique case (r_state)
        SEARCH: begin
          w_hist_nx = {din, r_hist[9:1]};
          if (r_fill != 4'd10)
            w_fill_nx = r_fill + 4'd1;
          else if (r_hist == '0 || din != w_pred)
            w_match_nx = '0;
          else
            w_match_nx = r_match + 8'd1;
          if (w_match_nx == 8'(LOCK_MATCH)) begin
            w_state_nx = LOCKED;
            w_miss_nx  = '0;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so a line error hits only once
          w_hist_nx = {w_pred, r_hist[9:1]};
          if (din != w_pred) begin
            w_err_nx  = 1'b1;
            w_miss_nx = r_miss + 8'd1;
            if (~&r_err_cnt)
              w_cnt_nx = r_err_cnt + ERR_W'(1);
          end else begin
            w_miss_nx = '0;
          end
          if (w_miss_nx == 8'(UNLOCK_ERR)) begin
            w_state_nx = SEARCH;
            w_fill_nx  = '0;
            w_match_nx = '0;
            w_miss_nx  = '0;
          end
        end
      endcase
    end
    if (w_clr) begin
      w_cnt_nx    = '0;
      w_cnt_nx[0] = w_err_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_hist      <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_miss      <= '0;
      r_lock      <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_hist      <= w_hist_nx;
      r_fill      <= w_fill_nx;
      r_match     <= w_match_nx;
      r_miss      <= w_miss_nx;
      r_lock      <= (w_state_nx == LOCKED);
      r_err_pulse <= w_err_nx;
      r_err_cnt   <= w_cnt_nx;
    end
  end

  assign lock       = r_lock;
  assign err_pulse  = r_err_pulse;
  assign err_cnt    = r_err_cnt;
  assign state_word = r_hist;

endmodule
